// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scanner states, calculator key constants and the
// (row, col) -> hex keymap used by keypad_scanner and the calculator top.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_EQUALS = 4'hE;
  localparam logic [3:0] KEY_CLEAR  = 4'hF;

  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = KEY_CLEAR;
      4'hE:    code = KEY_EQUALS;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Rows are active-low: exactly one zero means an unambiguous key.
  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << col_idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and hex key output.
// Optional auto-repeat strobes are built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0]    DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]          rs;
  state_t              state;
  logic [1:0]          col_idx;
  logic [1:0]          cap_row;
  logic [3:0]          captured;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DEB_W-1:0]    deb_cnt;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_TOP     = '1;

  logic [REP_W-1:0] rep_cnt;
  logic             rep_phase;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  sync_2ff #(
    .WIDTH       (4),
    .RESET_VALUE (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rs)
  );

  // Scan / debounce / hold / release state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      col_n      <= 4'b1110;
      cap_row    <= 2'd0;
      captured   <= 4'hF;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= '0;
      rep_phase  <= 1'b0;
`endif
    end else begin
      key_strobe <= 1'b0;
      case (state)
        SCAN: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            if (single_low(rs)) begin
              captured <= rs;
              cap_row  <= low_index(rs);
              deb_cnt  <= '0;
              state    <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_n   <= col_drive(col_idx + 2'd1);
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rs != captured) begin
            settle_cnt <= '0;
            deb_cnt    <= '0;
            state      <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            key_code   <= keymap(cap_row, col_idx);
            key_valid  <= 1'b1;
            key_strobe <= 1'b1;
            deb_cnt    <= '0;
            state      <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt    <= '0;
            rep_phase  <= 1'b0;
`endif
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (rs == 4'hF) begin
            deb_cnt <= '0;
            state   <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
`endif
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            if (rep_cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST)) begin
              key_strobe <= 1'b1;
              rep_cnt    <= '0;
              rep_phase  <= 1'b1;
            end else if (rep_cnt != REP_TOP) begin
              rep_cnt <= rep_cnt + 1'b1;
            end else begin
              rep_cnt <= rep_cnt;
            end
`else
            deb_cnt <= '0;
`endif
          end
        end

        RELEASE: begin
          if (rs != 4'hF) begin
            deb_cnt <= '0;
            state   <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            key_valid  <= 1'b0;
            deb_cnt    <= '0;
            settle_cnt <= '0;
            col_idx    <= col_idx + 2'd1;
            col_n      <= col_drive(col_idx + 2'd1);
            state      <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: begin
          settle_cnt <= '0;
          deb_cnt    <= '0;
          state      <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: table of single-key presses plus
// hand-written bounce, ambiguity, auto-repeat and reset-while-held sequences.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 16;
  localparam int RDELAY = 64;
  localparam int RPER   = 32;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_LONG = 60;
`else
  localparam int HOLD_LONG = 100;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  logic [15:0] key_mask;
  logic [3:0]  exp_q[$];
  int          checks;
  int          errors;
  int          strobe_cnt;
  logic        prev_strobe;

  typedef struct {
    string      name;
    int         row;
    int         col;
    int         hold;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[5];

  keypad_scanner #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDELAY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock, sampled on the falling edge; every strobe is scored against the queue.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (key_strobe) begin
      strobe_cnt++;
      check("strobe_not_back_to_back", int'(prev_strobe), 0);
      if (exp_q.size() == 0) check("strobe_expected_pending", exp_q.size(), 1);
      else check("strobe_code", int'(key_code), int'(exp_q.pop_front()));
    end
    prev_strobe = key_strobe;
  endtask

  task automatic wait_valid(input logic lvl, input int bound, input string name);
    int n;
    n = 0;
    while (key_valid !== lvl && n < bound) begin
      cycle();
      n++;
    end
    check(name, int'(key_valid), int'(lvl));
  endtask

  task automatic wait_col(input logic [3:0] pat, input int bound, input string name);
    int n;
    n = 0;
    while (col_n !== pat && n < bound) begin
      cycle();
      n++;
    end
    check(name, int'(col_n), int'(pat));
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_col;
    int         n;
    checks      = 0;
    errors      = 0;
    strobe_cnt  = 0;
    prev_strobe = 1'b0;
    key_mask    = 16'h0000;
    rst         = 1'b1;
    one         = 4'b0001;

    vecs[0] = '{"key_5", 1, 1, HOLD_LONG, 4'h5};
    vecs[1] = '{"key_1", 0, 0, 60, 4'h1};
    vecs[2] = '{"key_D", 3, 3, 60, 4'hD};
    vecs[3] = '{"key_9", 2, 2, 60, 4'h9};
    vecs[4] = '{"key_A", 0, 3, 60, 4'hA};

    // Reset values and the free-running column walk.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_strobe", int'(key_strobe), 0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_col = ~(one << ((i / 4) % 4));
      check("scan_col_seq", int'(col_n), int'(exp_col));
      cycle();
    end

    // Table of single-key presses: one strobe, correct code, valid held, code retained.
    for (int i = 0; i < 5; i++) begin
      strobe_cnt = 0;
      exp_q.push_back(vecs[i].code);
      key_mask = 16'h0001 << (vecs[i].row * 4 + vecs[i].col);
      repeat (vecs[i].hold) cycle();
      check({vecs[i].name, "_valid_held"}, int'(key_valid), 1);
      key_mask = 16'h0000;
      repeat (DEB) cycle();
      check({vecs[i].name, "_valid_after_release"}, int'(key_valid), 1);
      wait_valid(1'b0, 40, {vecs[i].name, "_valid_drop"});
      check({vecs[i].name, "_code_retained"}, int'(key_code), int'(vecs[i].code));
      check({vecs[i].name, "_strobe_count"}, strobe_cnt, 1);
      check({vecs[i].name, "_queue_drained"}, exp_q.size(), 0);
    end

    // Bouncing 'E': no strobe while bouncing, one after it settles.
    strobe_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      key_mask = 16'h4000;
      repeat (10) cycle();
      key_mask = 16'h0000;
      repeat (3) cycle();
    end
    check("bounce_no_strobe", strobe_cnt, 0);
    exp_q.push_back(4'hE);
    key_mask = 16'h4000;
    wait_valid(1'b1, 80, "bounce_E_accept");
    check("bounce_E_code", int'(key_code), 14);
    repeat (10) cycle();
    check("bounce_E_strobes", strobe_cnt, 1);
    key_mask = 16'h0000;
    wait_valid(1'b0, 60, "bounce_E_release");

    // Two rows low in column 0 is ambiguous: no key, scan moves on to column 1.
    strobe_cnt = 0;
    key_mask   = 16'h0101;
    wait_col(4'b1110, 20, "ambig_reach_col0");
    wait_col(4'b1101, 8, "ambig_advance_col1");
    repeat (40) cycle();
    check("ambig_no_valid", int'(key_valid), 0);
    check("ambig_no_strobe", strobe_cnt, 0);
    key_mask = 16'h0000;

    // Long hold of 'F'.
    strobe_cnt = 0;
    exp_q.push_back(4'hF);
    key_mask = 16'h2000;
    wait_valid(1'b1, 80, "hold_F_accept");
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(4'hF);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        cycle();
        n++;
      end
      check("repeat_interval", n, (k == 0) ? RDELAY : RPER);
    end
    check("repeat_strobe_count", strobe_cnt, 5);
`else
    repeat (200) cycle();
    check("hold_F_strobe_count", strobe_cnt, 1);
`endif
    check("hold_F_code", int'(key_code), 15);
    key_mask = 16'h0000;
    wait_valid(1'b0, 60, "hold_F_release");

    // Reset while '7' is held, then re-detection after reset.
    exp_q.push_back(4'h7);
    key_mask = 16'h0100;
    wait_valid(1'b1, 80, "rst7_accept");
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    check("rst7_valid_clear", int'(key_valid), 0);
    check("rst7_code_clear", int'(key_code), 0);
    check("rst7_strobe_clear", int'(key_strobe), 0);
    check("rst7_col_n", int'(col_n), 4'b1110);
    cycle();
    rst = 1'b0;
    strobe_cnt = 0;
    exp_q.push_back(4'h7);
    wait_valid(1'b1, 80, "rst7_redetect");
    repeat (20) cycle();
    check("rst7_strobe_count", strobe_cnt, 1);
    check("rst7_code", int'(key_code), 7);
    key_mask = 16'h0000;
    wait_valid(1'b0, 60, "rst7_release");
    check("final_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
